// File: rtl/regbank_writer_if.sv
// rtl/regbank_writer_if.sv - write/clear port bundle and flat read-out bus of the register file
interface regbank_writer_if #(
  parameter int WIDTH  = 32,
  parameter int ADDR_W = 5
);
  localparam int NREG = 2**ADDR_W;

  logic                  wren;
  logic [ADDR_W-1:0]     awr;
  logic [WIDTH-1:0]      din;
  logic                  clr;
  logic                  busy;
  logic                  wrack;
  logic [WIDTH*NREG-1:0] dout;

  modport master (
    output wren, awr, din, clr,
    input  busy, wrack, dout
  );

  modport slave (
    input  wren, awr, din, clr,
    output busy, wrack, dout
  );
endinterface

// File: rtl/regbank_writer.sv
// rtl/regbank_writer.sv - write side of the register file with one-hot write decode and clear sweep
module regbank_writer #(
  parameter int WIDTH  = 32,
  parameter int ADDR_W = 5
) (
  input  logic            clk,
  input  logic            rst_n,
  regbank_writer_if.slave bus
);
  localparam int NREG = 2**ADDR_W;

  typedef enum logic {
    IDLE  = 1'b0,
    CLEAR = 1'b1
  } state_t;

  state_t            state, state_nxt;
  logic [ADDR_W-1:0] cnt, cnt_nxt;
  logic              accept;
  logic              wrack_q;
  logic [NREG-1:1]   wr_sel;
  logic [NREG-1:1]   clr_sel;
  logic [WIDTH-1:0]  regs [NREG-1:1];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      cnt     <= '0;
      wrack_q <= 1'b0;
    end else begin
      state   <= state_nxt;
      cnt     <= cnt_nxt;
      wrack_q <= accept;
    end
  end

  // Clear outranks a same-edge write; the sweep starts at 1 since register 0 has no storage.
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    accept    = 1'b0;
    case (state)
      IDLE: begin
        if (bus.clr) begin
          state_nxt = CLEAR;
          cnt_nxt   = ADDR_W'(1);
        end else if (bus.wren) begin
          accept = 1'b1;
        end
      end
      CLEAR: begin
        if (cnt == ADDR_W'(NREG-1)) begin
          state_nxt = IDLE;
          cnt_nxt   = '0;
        end else begin
          cnt_nxt = cnt + ADDR_W'(1);
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    wr_sel  = '0;
    clr_sel = '0;
    for (int i = 1; i < NREG; i++) begin
      wr_sel[i]  = accept && (bus.awr == ADDR_W'(i));
      clr_sel[i] = (state == CLEAR) && (cnt == ADDR_W'(i));
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 1; i < NREG; i++) begin
        regs[i] <= '0;
      end
    end else begin
      for (int i = 1; i < NREG; i++) begin
        if (wr_sel[i]) begin
          regs[i] <= bus.din;
        end else if (clr_sel[i]) begin
          regs[i] <= '0;
        end
      end
    end
  end

  assign bus.busy  = (state == CLEAR);
  assign bus.wrack = wrack_q;

  assign bus.dout[WIDTH-1:0] = '0;
  for (genvar g = 1; g < NREG; g++) begin : g_dout
    assign bus.dout[g*WIDTH +: WIDTH] = regs[g];
  end
endmodule

// File: tb/tb_regbank_writer.sv
// tb/tb_regbank_writer.sv - scoreboard bench for regbank_writer
module tb_regbank_writer;
  localparam int WIDTH  = 32;
  localparam int ADDR_W = 5;
  localparam int NREG   = 2**ADDR_W;
  localparam int DW     = WIDTH*NREG;

  typedef struct packed {
    logic          busy;
    logic          wrack;
    logic [DW-1:0] dout;
  } exp_t;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;

  regbank_writer_if #(.WIDTH(WIDTH), .ADDR_W(ADDR_W)) bus ();

  regbank_writer #(.WIDTH(WIDTH), .ADDR_W(ADDR_W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  exp_t             sb_q[$];
  logic [WIDTH-1:0] m_regs [NREG];
  bit               m_busy;
  bit               m_ack;
  int               m_cnt;
  int               n_checks = 0;
  int               n_pass   = 0;

  task automatic check(input string tag, input logic [WIDTH-1:0] got, input logic [WIDTH-1:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask

  task automatic set_in(input bit w, input int a, input logic [WIDTH-1:0] d, input bit c);
    bus.wren = w;
    bus.awr  = ADDR_W'(a);
    bus.din  = d;
    bus.clr  = c;
  endtask

  task automatic m_reset();
    for (int k = 0; k < NREG; k++) m_regs[k] = '0;
    m_busy = 0;
    m_ack  = 0;
    m_cnt  = 0;
  endtask

  // Reference behaviour for one rising edge with the inputs currently driven.
  task automatic model_step();
    exp_t e;
    m_ack = 0;
    if (!m_busy) begin
      if (bus.clr) begin
        m_busy = 1;
        m_cnt  = 1;
      end else if (bus.wren) begin
        m_ack = 1;
        if (bus.awr != 0) m_regs[bus.awr] = bus.din;
      end
    end else begin
      m_regs[m_cnt] = '0;
      if (m_cnt == NREG-1) m_busy = 0;
      else m_cnt++;
    end
    e.busy  = m_busy;
    e.wrack = m_ack;
    for (int k = 0; k < NREG; k++) e.dout[k*WIDTH +: WIDTH] = m_regs[k];
    sb_q.push_back(e);
  endtask

  task automatic tick();
    exp_t o;
    model_step();
    @(posedge clk);
    #1;
    o = sb_q.pop_front();
    check("busy", WIDTH'(bus.busy), WIDTH'(o.busy));
    check("wrack", WIDTH'(bus.wrack), WIDTH'(o.wrack));
    for (int k = 0; k < NREG; k++)
      check($sformatf("dout[%0d]", k), bus.dout[k*WIDTH +: WIDTH], o.dout[k*WIDTH +: WIDTH]);
  endtask

  task automatic check_zero_now(input string tag);
    check({tag, "_busy"}, WIDTH'(bus.busy), '0);
    check({tag, "_wrack"}, WIDTH'(bus.wrack), '0);
    for (int k = 0; k < NREG; k++)
      check($sformatf("%s_dout[%0d]", tag, k), bus.dout[k*WIDTH +: WIDTH], '0);
  endtask

  int busy_cnt;
  bit hist [80];
  int run1, gap, run2, idx;

  initial begin
    set_in(0, 0, '0, 0);
    m_reset();
    repeat (2) @(posedge clk);
    #1;
    check_zero_now("reset");
    #4 rst_n = 1'b1;

    // basic back-to-back writes
    set_in(1, 5, 32'hDEADBEEF, 0);  tick();
    check("wr5_slice", bus.dout[5*WIDTH +: WIDTH], 32'hDEADBEEF);
    set_in(1, 31, 32'h12345678, 0); tick();
    check("wr31_slice", bus.dout[31*WIDTH +: WIDTH], 32'h12345678);
    set_in(0, 0, '0, 0);            tick();

    // register 0 protection
    set_in(1, 0, 32'hFFFFFFFF, 0);  tick();
    check("r0_ack", WIDTH'(bus.wrack), 32'd1);
    set_in(0, 0, '0, 0);            tick();

    // fill then full clear with a refused write mid-sweep
    for (int i = 1; i < NREG; i++) begin
      set_in(1, i, WIDTH'(i), 0);
      tick();
    end
    set_in(0, 0, '0, 1);
    tick();
    busy_cnt = int'(bus.busy);
    for (int j = 1; j <= 31; j++) begin
      if (j == 5) set_in(1, 3, 32'h0000AAAA, 0);
      else        set_in(0, 0, '0, 0);
      tick();
      busy_cnt += int'(bus.busy);
    end
    check("clear_busy_cycles", busy_cnt, 32'd31);
    check("busy_write_dropped", bus.dout[3*WIDTH +: WIDTH], '0);
    set_in(1, 9, 32'h00000099, 0);
    tick();
    check("write_after_clear_ack", WIDTH'(bus.wrack), 32'd1);

    // simultaneous clear and write
    set_in(1, 7, 32'h00000077, 0);  tick();
    set_in(1, 7, 32'h00000055, 1);  tick();
    check("clr_wins_no_ack", WIDTH'(bus.wrack), '0);
    set_in(0, 0, '0, 0);
    repeat (31) tick();
    check("clr_wins_slice7", bus.dout[7*WIDTH +: WIDTH], '0);

    // asynchronous reset in the middle of a sweep
    set_in(1, 12, 32'hCAFEF00D, 0); tick();
    set_in(0, 0, '0, 1);            tick();
    set_in(0, 0, '0, 0);
    repeat (9) tick();
    #3 rst_n = 1'b0;
    m_reset();
    #1;
    check_zero_now("async_rst");
    @(posedge clk);
    #1;
    check("rst_held_busy", WIDTH'(bus.busy), '0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (3) tick();
    set_in(1, 20, 32'h00000001, 0); tick();
    check("post_rst_wr20", bus.dout[20*WIDTH +: WIDTH], 32'h00000001);
    set_in(0, 0, '0, 0);            tick();

    // Clr held high for 40 cycles
    set_in(0, 0, '0, 1);
    for (int c = 0; c < 80; c++) begin
      if (c == 40) set_in(0, 0, '0, 0);
      tick();
      hist[c] = bus.busy;
    end
    run1 = 0; gap = 0; run2 = 0; idx = 0;
    while (idx < 80 && hist[idx])  begin run1++; idx++; end
    while (idx < 80 && !hist[idx]) begin gap++;  idx++; end
    while (idx < 80 && hist[idx])  begin run2++; idx++; end
    check("held_first_sweep", run1, 32'd31);
    check("held_idle_gap", gap, 32'd1);
    check("held_second_sweep", run2, 32'd31);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule

// File: doc/regbank_writer.md
# regbank_writer

Write side of the 32×32 register file. It takes one write per cycle through an address-decoded write-enable, and a multi-cycle clear request sweeps every register back to zero. All register contents leave on a flat bus that feeds the 32:1 read multiplexers. Register 0 is hardwired to zero.

## Interface

Parameters:
- `WIDTH`, default 32: data width of each register.
- `ADDR_W`, default 5: address width. Register count is `NREG = 2**ADDR_W` (32).

Ports:
- `Clk`  input  1  single clock, rising edge.
- `Rst_n`  input  1  reset, asynchronous and active-low.
- `WrEn`  input  1  write request, sampled on the rising edge of `Clk`.
- `Awr`  input  ADDR_W  write address.
- `Din`  input  WIDTH  write data.
- `Clr`  input  1  clear-all request, level sampled.
- `Busy`  output  1  high while the clear sweep runs. Writes are refused while `Busy` is high.
- `WrAck`  output  1  one-cycle pulse for each write accepted.
- `Dout`  output  WIDTH*NREG  register contents. Register i is at `Dout[i*WIDTH +: WIDTH]`.

## Operation

- **State machine:** two states, IDLE and CLEAR. `Busy` = (state == CLEAR), decoded directly from the state register.
- **Address decode:** `Awr` decodes to a one-hot enable vector of NREG bits, gated by `WrEn`, by IDLE and by `!Clr`.
- **Accepted write:** in IDLE with `WrEn`=1 and `Clr`=0, `reg[Awr] <= Din` on that edge.
- **Register 0:** a write to address 0 is accepted and acknowledged but stores nothing. `Dout[WIDTH-1:0]` is constant 0.
- **WrAck:** registered. It is high for exactly the cycle after the edge that accepted a write. Refused writes produce no `WrAck`.
- **Clear priority:** when `Clr`=1 in IDLE, clear wins over a same-edge write. That write is dropped: no register update and no `WrAck`. The state moves to CLEAR and the sweep counter `cnt` (ADDR_W bits) is loaded with 1.
- **Clear sweep:** each edge in CLEAR does `reg[cnt] <= 0` and `cnt <= cnt + 1`.
  - On the edge where `cnt == NREG-1`, that register is cleared and the state returns to IDLE.
  - `cnt` never wraps into register 0.
- **Clr while busy:** `Clr` is ignored during CLEAR. If `Clr` is still high in the first IDLE cycle, a new sweep starts (level-sensitive).
- **WrEn while busy:** `WrEn` during CLEAR is dropped silently, whatever the address.
- **Reset:** reset is asynchronous, applied at any time including mid-sweep. It forces:
  - all registers to 0;
  - state to IDLE and `cnt` to 0;
  - `Busy` = 0 and `WrAck` = 0.
  
  An aborted sweep does not resume after reset is released.
- **Data path:** no arithmetic. Data is stored bit-exact; no truncation or extension.

## Timing

- **Write latency:** 1 cycle. A write accepted at edge T is visible on `Dout` after edge T. `WrAck` is high between edges T and T+1.
- **Back-to-back writes:** one per cycle, no bubbles. Writes to the same address on consecutive edges: the last one wins.
- **Clear timing:** with `Clr` sampled at edge T in IDLE:
  - `Busy` is high from just after edge T until edge T+NREG-1 (31 cycles).
  - Register k is zero after edge T+k, for k = 1..31.
  - The first write that can be accepted is at edge T+NREG.
- **Outputs after reset release:** `Dout` is all zeros, `Busy` = 0 and `WrAck` = 0 until the first accepted event.

## Test plan

- **Reset then basic writes:** release reset, write 0xDEADBEEF to 5 and 0x12345678 to 31 on consecutive edges.
  - `Dout` slices 5 and 31 hold those values one cycle after each write.
  - `WrAck` is high for 2 consecutive cycles.
  - Every other slice stays 0.
- **Register 0 protection:** write 0xFFFFFFFF to address 0.
  - `WrAck` pulses once.
  - Slice 0 stays 0x00000000.
- **Full clear:** fill registers 1..31 with value i, then pulse `Clr` at edge T.
  - `Busy` is high for exactly 31 cycles.
  - Slice k becomes 0 after edge T+k.
  - `WrEn` at address 3 with 0xAAAA during `Busy` is dropped: no `WrAck`, and slice 3 is still 0 afterwards.
  - A write at edge T+32 succeeds.
- **Simultaneous Clr and WrEn in IDLE:** assert `Clr`=1 and `WrEn`=1 with `Awr`=7 and `Din`=0x55 on the same edge.
  - No `WrAck`.
  - The sweep starts and slice 7 ends at 0.
- **Reset mid-sweep:** assert `Rst_n`=0 asynchronously between clock edges at sweep cycle 10.
  - `Busy` drops immediately and all slices read 0.
  - After release, `Busy` stays 0 with `Clr` low.
  - A write to address 20 with 0x1 works with 1-cycle latency.
- **Held Clr:** hold `Clr` high for 40 cycles.
  - The first sweep completes, there is 1 IDLE cycle, then a second sweep starts (`Busy` high again for 31 cycles).
